prv664_commit_unit: RTL and testbench

In-order retirement stage for prv664. Sits on the read side of the ROB read interface and pops the head entry once it is complete. It then either writes architectural state (GPR, FPR, CSR, fflags), or raises a trap or xret to the CSR unit, or redirects the front end. Every retirement that changes control flow is followed by a one-cycle pipeline flush with a new fetch PC.

---
 rtl/prv664_commit_pkg.sv | 80 ++++++++
 rtl/prv664_trap_encode.sv | 35 +++
 rtl/prv664_commit_unit.sv | 175 +++++++++++++++++
 tb/tb_prv664_commit_unit.sv | 325 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/prv664_commit_pkg.sv
// prv664_commit_pkg
//   Shared types and constants for the prv664 in-order commit stage:
//   FSM states, exception bit layout of a ROB entry, trap kinds, the
//   RISC-V mcause codes used at retirement and the cause priority encoder.
package prv664_commit_pkg;

    localparam int XLEN   = 64;
    localparam int ROBTAG = 8;

    typedef enum logic [1:0] {
        ST_RUN     = 2'd0,
        ST_IRRWAIT = 2'd1,
        ST_TRAP    = 2'd2,
        ST_FLUSH   = 2'd3
    } commit_state_e;

    typedef enum logic [1:0] {
        KIND_TRAP = 2'd0,
        KIND_MRET = 2'd1,
        KIND_SRET = 2'd2
    } trap_kind_e;

    // Exception flags carried by a ROB entry; first member is the MSB.
    typedef struct packed {
        logic instr_addrmis;
        logic instr_accflt;
        logic instr_pageflt;
        logic illins;
        logic load_addrmis;
        logic load_accflt;
        logic load_pageflt;
        logic store_addrmis;
        logic store_accflt;
        logic store_pageflt;
    } excp_t;

    localparam logic [4:0] CAUSE_INSTR_ADDRMIS = 5'd0;
    localparam logic [4:0] CAUSE_INSTR_ACCFLT  = 5'd1;
    localparam logic [4:0] CAUSE_ILLINS        = 5'd2;
    localparam logic [4:0] CAUSE_BREAKPOINT    = 5'd3;
    localparam logic [4:0] CAUSE_LOAD_ADDRMIS  = 5'd4;
    localparam logic [4:0] CAUSE_LOAD_ACCFLT   = 5'd5;
    localparam logic [4:0] CAUSE_STORE_ADDRMIS = 5'd6;
    localparam logic [4:0] CAUSE_STORE_ACCFLT  = 5'd7;
    localparam logic [4:0] CAUSE_ECALL_U       = 5'd8;
    localparam logic [4:0] CAUSE_INSTR_PAGEFLT = 5'd12;
    localparam logic [4:0] CAUSE_LOAD_PAGEFLT  = 5'd13;
    localparam logic [4:0] CAUSE_STORE_PAGEFLT = 5'd15;

    typedef struct packed {
        logic       hit;
        logic [4:0] code;
    } cause_t;

    // Highest-priority synchronous exception of a retiring entry.
    // ecall codes are consecutive by privilege (U=8, S=9, M=11).
    function automatic cause_t encode_cause(excp_t e, logic ecall, logic ebreak,
                                            logic [1:0] priv);
        cause_t c;
        c.hit = 1'b1;
        if      (e.instr_pageflt) c.code = CAUSE_INSTR_PAGEFLT;
        else if (e.instr_accflt)  c.code = CAUSE_INSTR_ACCFLT;
        else if (e.instr_addrmis) c.code = CAUSE_INSTR_ADDRMIS;
        else if (e.illins)        c.code = CAUSE_ILLINS;
        else if (ebreak)          c.code = CAUSE_BREAKPOINT;
        else if (ecall)           c.code = CAUSE_ECALL_U + {3'b000, priv};
        else if (e.load_addrmis)  c.code = CAUSE_LOAD_ADDRMIS;
        else if (e.store_addrmis) c.code = CAUSE_STORE_ADDRMIS;
        else if (e.load_pageflt)  c.code = CAUSE_LOAD_PAGEFLT;
        else if (e.store_pageflt) c.code = CAUSE_STORE_PAGEFLT;
        else if (e.load_accflt)   c.code = CAUSE_LOAD_ACCFLT;
        else if (e.store_accflt)  c.code = CAUSE_STORE_ACCFLT;
        else begin
            c.hit  = 1'b0;
            c.code = '0;
        end
        return c;
    endfunction

endpackage

// File: rtl/prv664_trap_encode.sv
// prv664_trap_encode
//   Combinational classification of the ROB head: does retiring it divert
//   to the CSR unit, and if so with which kind and cause.
//   excp_i/ecall_i/ebreak_i/mret_i/sret_i : head flags
//   priv_i   : current privilege (selects the ecall cause)
//   trap_o   : head needs the CSR unit (exception, ecall, ebreak, xret)
//   kind_o   : trap / mret / sret; an exception outranks an xret
//   cause_o  : mcause code, 0 for xret
module prv664_trap_encode
    import prv664_commit_pkg::*;
(
    input  excp_t       excp_i,
    input  logic        ecall_i,
    input  logic        ebreak_i,
    input  logic        mret_i,
    input  logic        sret_i,
    input  logic [1:0]  priv_i,
    output logic        trap_o,
    output trap_kind_e  kind_o,
    output logic [4:0]  cause_o
);

    cause_t c;

    always_comb begin
        c       = encode_cause(excp_i, ecall_i, ebreak_i, priv_i);
        cause_o = c.code;
        trap_o  = c.hit | mret_i | sret_i;
        if (c.hit)       kind_o = KIND_TRAP;
        else if (mret_i) kind_o = KIND_MRET;
        else if (sret_i) kind_o = KIND_SRET;
        else             kind_o = KIND_TRAP;
    end

endmodule

// File: rtl/prv664_commit_unit.sv
// prv664_commit_unit
//   In-order retirement: pops the completed ROB head and either writes
//   architectural state, hands a trap/xret to the CSR unit, or redirects
//   fetch. Every control-flow change ends in a one-cycle flush.
//   rob_*        : ROB head entry and pop handshake (rob_ready_o)
//   priv_i       : current privilege level
//   gpr/fpr/csr/fflag_* : registered architectural writes
//   irrevo_*     : one-shot go for an irrevocable, not yet executed head
//   trap_*       : trap/xret request to the CSR unit, target comes back
//   flush_o/redirect_pc_o : pipeline flush with new fetch PC
//   instret_o    : one pulse per retired instruction
module prv664_commit_unit
    import prv664_commit_pkg::*;
(
    input  logic              clk_i,
    input  logic              arstn_i,
    input  logic              rob_valid_i,
    input  logic              rob_complete_i,
    output logic              rob_ready_o,
    input  logic [ROBTAG-1:0] rob_itag_i,
    input  logic [XLEN-1:0]   rob_pc_i,
    input  logic [XLEN-1:0]   rob_data_i,
    input  logic [XLEN-1:0]   rob_csrdata_i,
    input  logic [XLEN-1:0]   rob_branchaddr_i,
    input  excp_t             rob_excp_i,
    input  logic              rob_ecall_i,
    input  logic              rob_ebreak_i,
    input  logic              rob_mret_i,
    input  logic              rob_sret_i,
    input  logic              rob_jump_i,
    input  logic              rob_irrevo_i,
    input  logic              rob_rden_i,
    input  logic [4:0]        rob_rdindex_i,
    input  logic              rob_frden_i,
    input  logic [4:0]        rob_frdindex_i,
    input  logic              rob_csren_i,
    input  logic [11:0]       rob_csrindex_i,
    input  logic              rob_fflagen_i,
    input  logic [4:0]        rob_fflag_i,
    input  logic [1:0]        priv_i,
    output logic              gpr_we_o,
    output logic [4:0]        gpr_idx_o,
    output logic [XLEN-1:0]   gpr_data_o,
    output logic              fpr_we_o,
    output logic [4:0]        fpr_idx_o,
    output logic [XLEN-1:0]   fpr_data_o,
    output logic              csr_we_o,
    output logic [11:0]       csr_idx_o,
    output logic [XLEN-1:0]   csr_data_o,
    output logic              fflag_we_o,
    output logic [4:0]        fflag_o,
    output logic              irrevo_go_o,
    output logic [ROBTAG-1:0] irrevo_itag_o,
    output logic              trap_valid_o,
    input  logic              trap_ready_i,
    output logic [1:0]        trap_kind_o,
    output logic [4:0]        trap_cause_o,
    output logic [XLEN-1:0]   trap_epc_o,
    input  logic [XLEN-1:0]   trap_target_i,
    output logic              flush_o,
    output logic [XLEN-1:0]   redirect_pc_o,
    output logic              instret_o
);

    commit_state_e state_q, state_d;
    logic          irrevo_go_d;
    logic          head_trap;
    trap_kind_e    head_kind;
    logic [4:0]    head_cause;
    logic          pop_plain;
    logic          trap_accept;

    prv664_trap_encode u_trap_encode (
        .excp_i   (rob_excp_i),
        .ecall_i  (rob_ecall_i),
        .ebreak_i (rob_ebreak_i),
        .mret_i   (rob_mret_i),
        .sret_i   (rob_sret_i),
        .priv_i   (priv_i),
        .trap_o   (head_trap),
        .kind_o   (head_kind),
        .cause_o  (head_cause)
    );

    // NOTE: every signal written here gets a default first, so no path
    // leaves it unassigned and no latch is inferred.
    always_comb begin
        state_d     = state_q;
        rob_ready_o = 1'b0;
        irrevo_go_d = 1'b0;
        unique case (state_q)
            ST_RUN, ST_IRRWAIT: begin
                // Gated by reset so the pop handshake is also quiet while
                // arstn_i is held low.
                rob_ready_o = arstn_i & rob_valid_i & rob_complete_i;
                if (rob_ready_o) begin
                    if (head_trap)       state_d = ST_TRAP;
                    else if (rob_jump_i) state_d = ST_FLUSH;
                    else                 state_d = ST_RUN;
                end else if (state_q == ST_RUN && rob_valid_i && rob_irrevo_i) begin
                    // IRRWAIT remembers the go was given for this head.
                    irrevo_go_d = 1'b1;
                    state_d     = ST_IRRWAIT;
                end
            end
            ST_TRAP:  if (trap_ready_i) state_d = ST_FLUSH;
            ST_FLUSH: state_d = ST_RUN;
            default:  state_d = ST_RUN;
        endcase
    end

    assign pop_plain   = rob_ready_o & ~head_trap;
    assign trap_accept = (state_q == ST_TRAP) & trap_ready_i;
    assign flush_o     = (state_q == ST_FLUSH);

    // NOTE: sequential state uses non-blocking assignments so all registers
    // update together from the values sampled at the clock edge.
    always_ff @(posedge clk_i or negedge arstn_i) begin
        if (!arstn_i) begin
            state_q       <= ST_RUN;
            gpr_we_o      <= 1'b0;
            gpr_idx_o     <= '0;
            gpr_data_o    <= '0;
            fpr_we_o      <= 1'b0;
            fpr_idx_o     <= '0;
            fpr_data_o    <= '0;
            csr_we_o      <= 1'b0;
            csr_idx_o     <= '0;
            csr_data_o    <= '0;
            fflag_we_o    <= 1'b0;
            fflag_o       <= '0;
            irrevo_go_o   <= 1'b0;
            irrevo_itag_o <= '0;
            trap_valid_o  <= 1'b0;
            trap_kind_o   <= '0;
            trap_cause_o  <= '0;
            trap_epc_o    <= '0;
            redirect_pc_o <= '0;
            instret_o     <= 1'b0;
        end else begin
            state_q    <= state_d;
            gpr_we_o   <= pop_plain & rob_rden_i & (rob_rdindex_i != 5'd0);
            fpr_we_o   <= pop_plain & rob_frden_i;
            csr_we_o   <= pop_plain & rob_csren_i;
            fflag_we_o <= pop_plain & rob_fflagen_i;
            // xret retires an instruction; an exception does not.
            instret_o  <= pop_plain | (rob_ready_o & head_trap & (head_kind != KIND_TRAP));
            if (rob_ready_o) begin
                gpr_idx_o  <= rob_rdindex_i;
                gpr_data_o <= rob_data_i;
                fpr_idx_o  <= rob_frdindex_i;
                fpr_data_o <= rob_data_i;
                csr_idx_o  <= rob_csrindex_i;
                csr_data_o <= rob_csrdata_i;
                fflag_o    <= rob_fflag_i;
            end

            irrevo_go_o <= irrevo_go_d;
            if (irrevo_go_d) irrevo_itag_o <= rob_itag_i;

            if (rob_ready_o && head_trap) begin
                trap_valid_o <= 1'b1;
                trap_kind_o  <= head_kind;
                trap_cause_o <= head_cause;
                trap_epc_o   <= rob_pc_i;
            end else if (trap_accept) begin
                trap_valid_o <= 1'b0;
            end

            if (pop_plain && rob_jump_i) redirect_pc_o <= rob_branchaddr_i;
            else if (trap_accept)        redirect_pc_o <= trap_target_i;
        end
    end

endmodule

// File: tb/tb_prv664_commit_unit.sv
// tb_prv664_commit_unit
//   Self-checking bench for prv664_commit_unit: directed scenarios plus a
//   randomized stream of ROB heads, each scored against a reference model
//   derived from the retirement rules (cause priority table, write masks).
module tb_prv664_commit_unit;
    import prv664_commit_pkg::*;

    logic              clk_i = 1'b0;
    logic              arstn_i = 1'b0;
    logic              rob_valid_i = 1'b0, rob_complete_i = 1'b0;
    logic              rob_ready_o;
    logic [ROBTAG-1:0] rob_itag_i = '0;
    logic [XLEN-1:0]   rob_pc_i = '0, rob_data_i = '0, rob_csrdata_i = '0, rob_branchaddr_i = '0;
    excp_t             rob_excp_i = '0;
    logic              rob_ecall_i = 0, rob_ebreak_i = 0, rob_mret_i = 0, rob_sret_i = 0;
    logic              rob_jump_i = 0, rob_irrevo_i = 0;
    logic              rob_rden_i = 0, rob_frden_i = 0, rob_csren_i = 0, rob_fflagen_i = 0;
    logic [4:0]        rob_rdindex_i = '0, rob_frdindex_i = '0, rob_fflag_i = '0;
    logic [11:0]       rob_csrindex_i = '0;
    logic [1:0]        priv_i = '0;
    logic              gpr_we_o, fpr_we_o, csr_we_o, fflag_we_o;
    logic [4:0]        gpr_idx_o, fpr_idx_o, fflag_o;
    logic [11:0]       csr_idx_o;
    logic [XLEN-1:0]   gpr_data_o, fpr_data_o, csr_data_o;
    logic              irrevo_go_o;
    logic [ROBTAG-1:0] irrevo_itag_o;
    logic              trap_valid_o;
    logic              trap_ready_i = 1'b0;
    logic [1:0]        trap_kind_o;
    logic [4:0]        trap_cause_o;
    logic [XLEN-1:0]   trap_epc_o, redirect_pc_o;
    logic [XLEN-1:0]   trap_target_i = '0;
    logic              flush_o, instret_o;

    int total = 0;
    int bad   = 0;

    prv664_commit_unit dut (
        .clk_i(clk_i), .arstn_i(arstn_i),
        .rob_valid_i(rob_valid_i), .rob_complete_i(rob_complete_i), .rob_ready_o(rob_ready_o),
        .rob_itag_i(rob_itag_i), .rob_pc_i(rob_pc_i), .rob_data_i(rob_data_i),
        .rob_csrdata_i(rob_csrdata_i), .rob_branchaddr_i(rob_branchaddr_i),
        .rob_excp_i(rob_excp_i), .rob_ecall_i(rob_ecall_i), .rob_ebreak_i(rob_ebreak_i),
        .rob_mret_i(rob_mret_i), .rob_sret_i(rob_sret_i), .rob_jump_i(rob_jump_i),
        .rob_irrevo_i(rob_irrevo_i), .rob_rden_i(rob_rden_i), .rob_rdindex_i(rob_rdindex_i),
        .rob_frden_i(rob_frden_i), .rob_frdindex_i(rob_frdindex_i),
        .rob_csren_i(rob_csren_i), .rob_csrindex_i(rob_csrindex_i),
        .rob_fflagen_i(rob_fflagen_i), .rob_fflag_i(rob_fflag_i), .priv_i(priv_i),
        .gpr_we_o(gpr_we_o), .gpr_idx_o(gpr_idx_o), .gpr_data_o(gpr_data_o),
        .fpr_we_o(fpr_we_o), .fpr_idx_o(fpr_idx_o), .fpr_data_o(fpr_data_o),
        .csr_we_o(csr_we_o), .csr_idx_o(csr_idx_o), .csr_data_o(csr_data_o),
        .fflag_we_o(fflag_we_o), .fflag_o(fflag_o),
        .irrevo_go_o(irrevo_go_o), .irrevo_itag_o(irrevo_itag_o),
        .trap_valid_o(trap_valid_o), .trap_ready_i(trap_ready_i), .trap_kind_o(trap_kind_o),
        .trap_cause_o(trap_cause_o), .trap_epc_o(trap_epc_o), .trap_target_i(trap_target_i),
        .flush_o(flush_o), .redirect_pc_o(redirect_pc_o), .instret_o(instret_o)
    );

    always #5 clk_i = ~clk_i;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    typedef struct {
        logic [XLEN-1:0]   pc, data, csrdata, branch;
        excp_t             excp;
        logic              ecall, ebreak, mret, sret, jump, irrevo;
        logic              rden, frden, csren, fflagen;
        logic [4:0]        rdidx, frdidx, fflag;
        logic [11:0]       csridx;
        logic [ROBTAG-1:0] itag;
        logic [1:0]        priv;
    } head_t;

    function automatic head_t blank_head();
        head_t h;
        h.pc = '0; h.data = '0; h.csrdata = '0; h.branch = '0; h.excp = '0;
        h.ecall = 0; h.ebreak = 0; h.mret = 0; h.sret = 0; h.jump = 0; h.irrevo = 0;
        h.rden = 0; h.frden = 0; h.csren = 0; h.fflagen = 0;
        h.rdidx = '0; h.frdidx = '0; h.fflag = '0; h.csridx = '0;
        h.itag = 8'($urandom); h.priv = 2'd3;
        return h;
    endfunction

    // Reference: walk the cause table in priority order; first present wins.
    function automatic void model_trap(input head_t h, output logic t,
                                       output logic [4:0] c, output logic [1:0] k);
        logic [11:0] present;
        int          code [12];
        present = {h.excp.instr_pageflt, h.excp.instr_accflt, h.excp.instr_addrmis,
                   h.excp.illins, h.ebreak, h.ecall, h.excp.load_addrmis,
                   h.excp.store_addrmis, h.excp.load_pageflt, h.excp.store_pageflt,
                   h.excp.load_accflt, h.excp.store_accflt};
        code = '{12, 1, 0, 2, 3, 8 + int'(h.priv), 4, 6, 13, 15, 5, 7};
        t = 0; c = '0; k = 2'd0;
        for (int i = 0; i < 12; i++) begin
            if (present[11-i]) begin
                t = 1; c = 5'(code[i]);
                break;
            end
        end
        if (!t && h.mret)      begin t = 1; k = 2'd1; end
        else if (!t && h.sret) begin t = 1; k = 2'd2; end
    endfunction

    task automatic drive_head(input head_t h);
        rob_itag_i = h.itag; rob_pc_i = h.pc; rob_data_i = h.data;
        rob_csrdata_i = h.csrdata; rob_branchaddr_i = h.branch; rob_excp_i = h.excp;
        rob_ecall_i = h.ecall; rob_ebreak_i = h.ebreak; rob_mret_i = h.mret;
        rob_sret_i = h.sret; rob_jump_i = h.jump; rob_irrevo_i = h.irrevo;
        rob_rden_i = h.rden; rob_rdindex_i = h.rdidx; rob_frden_i = h.frden;
        rob_frdindex_i = h.frdidx; rob_csren_i = h.csren; rob_csrindex_i = h.csridx;
        rob_fflagen_i = h.fflagen; rob_fflag_i = h.fflag; priv_i = h.priv;
    endtask

    // Present one head (incomplete for prewait cycles), pop it and score
    // every consequence up to the return to normal running.
    task automatic retire(input head_t h, input int prewait, input int delay,
                          input logic [XLEN-1:0] target);
        logic       et, egwe, eflush, einstret;
        logic [4:0] ec;
        logic [1:0] ek;
        int         pulses, exp_pulses;
        model_trap(h, et, ec, ek);
        egwe     = !et && h.rden && (h.rdidx != 5'd0);
        eflush   = !et && h.jump;
        einstret = !et || (ek != 2'd0);
        exp_pulses = (h.irrevo && prewait > 0) ? 1 : 0;
        pulses = 0;

        @(posedge clk_i); #1;
        drive_head(h);
        rob_valid_i = 1'b1;
        rob_complete_i = (prewait == 0);
        for (int i = 0; i < prewait; i++) begin
            @(negedge clk_i);
            total++; if (rob_ready_o !== 1'b0) begin bad++; $display("FAIL ready_incomplete got=%0b exp=0", rob_ready_o); end
            if (irrevo_go_o === 1'b1) begin
                pulses++;
                total++; if (irrevo_itag_o !== h.itag) begin bad++; $display("FAIL irrevo_itag got=%h exp=%h", irrevo_itag_o, h.itag); end
            end
            @(posedge clk_i); #1;
        end
        rob_complete_i = 1'b1;
        @(negedge clk_i);
        if (irrevo_go_o === 1'b1) begin
            pulses++;
            total++; if (irrevo_itag_o !== h.itag) begin bad++; $display("FAIL irrevo_itag got=%h exp=%h", irrevo_itag_o, h.itag); end
        end
        total++; if (rob_ready_o !== 1'b1) begin bad++; $display("FAIL ready_pop got=%0b exp=1", rob_ready_o); end
        total++; if (pulses != exp_pulses) begin bad++; $display("FAIL irrevo_pulses got=%0d exp=%0d", pulses, exp_pulses); end

        // Pop happens at this edge. Keep a head visible when the unit must
        // refuse to pop (flush or trap cycle).
        @(posedge clk_i); #1;
        rob_valid_i  = et || h.jump;
        trap_ready_i = et && (delay == 0);
        trap_target_i = target;
        @(negedge clk_i);
        total++; if (gpr_we_o !== egwe) begin bad++; $display("FAIL gpr_we got=%0b exp=%0b", gpr_we_o, egwe); end
        if (egwe) begin
            total++; if ({gpr_idx_o, gpr_data_o} !== {h.rdidx, h.data}) begin bad++; $display("FAIL gpr_write got=%0d/%h exp=%0d/%h", gpr_idx_o, gpr_data_o, h.rdidx, h.data); end
        end
        total++; if (fpr_we_o !== (!et && h.frden)) begin bad++; $display("FAIL fpr_we got=%0b exp=%0b", fpr_we_o, !et && h.frden); end
        if (!et && h.frden) begin
            total++; if ({fpr_idx_o, fpr_data_o} !== {h.frdidx, h.data}) begin bad++; $display("FAIL fpr_write got=%0d/%h exp=%0d/%h", fpr_idx_o, fpr_data_o, h.frdidx, h.data); end
        end
        total++; if (csr_we_o !== (!et && h.csren)) begin bad++; $display("FAIL csr_we got=%0b exp=%0b", csr_we_o, !et && h.csren); end
        if (!et && h.csren) begin
            total++; if ({csr_idx_o, csr_data_o} !== {h.csridx, h.csrdata}) begin bad++; $display("FAIL csr_write got=%h/%h exp=%h/%h", csr_idx_o, csr_data_o, h.csridx, h.csrdata); end
        end
        total++; if (fflag_we_o !== (!et && h.fflagen)) begin bad++; $display("FAIL fflag_we got=%0b exp=%0b", fflag_we_o, !et && h.fflagen); end
        if (!et && h.fflagen) begin
            total++; if (fflag_o !== h.fflag) begin bad++; $display("FAIL fflag got=%h exp=%h", fflag_o, h.fflag); end
        end
        total++; if (instret_o !== einstret) begin bad++; $display("FAIL instret got=%0b exp=%0b", instret_o, einstret); end
        total++; if (flush_o !== eflush) begin bad++; $display("FAIL flush_after_pop got=%0b exp=%0b", flush_o, eflush); end
        total++; if (trap_valid_o !== et) begin bad++; $display("FAIL trap_valid got=%0b exp=%0b", trap_valid_o, et); end
        total++; if (irrevo_go_o !== 1'b0) begin bad++; $display("FAIL irrevo_after_pop got=%0b exp=0", irrevo_go_o); end
        if (eflush) begin
            total++; if (redirect_pc_o !== h.branch) begin bad++; $display("FAIL jump_redirect got=%h exp=%h", redirect_pc_o, h.branch); end
            total++; if (rob_ready_o !== 1'b0) begin bad++; $display("FAIL ready_in_flush got=%0b exp=0", rob_ready_o); end
        end
        if (et) begin
            total++; if (trap_kind_o !== ek) begin bad++; $display("FAIL trap_kind got=%0d exp=%0d", trap_kind_o, ek); end
            if (ek == 2'd0) begin
                total++; if (trap_cause_o !== ec) begin bad++; $display("FAIL trap_cause got=%0d exp=%0d", trap_cause_o, ec); end
            end
            total++; if (trap_epc_o !== h.pc) begin bad++; $display("FAIL trap_epc got=%h exp=%h", trap_epc_o, h.pc); end
            total++; if (rob_ready_o !== 1'b0) begin bad++; $display("FAIL ready_in_trap got=%0b exp=0", rob_ready_o); end
            for (int d = 1; d <= delay; d++) begin
                @(posedge clk_i); #1;
                trap_ready_i = (d == delay);
                @(negedge clk_i);
                total++; if ({trap_valid_o, flush_o, trap_epc_o} !== {1'b1, 1'b0, h.pc}) begin bad++; $display("FAIL trap_hold got=%0b/%0b/%h exp=1/0/%h", trap_valid_o, flush_o, trap_epc_o, h.pc); end
            end
            @(posedge clk_i); #1;
            trap_ready_i = 1'b0;
            trap_target_i = '0;
            @(negedge clk_i);
            total++; if (flush_o !== 1'b1) begin bad++; $display("FAIL trap_flush got=%0b exp=1", flush_o); end
            total++; if (redirect_pc_o !== target) begin bad++; $display("FAIL trap_redirect got=%h exp=%h", redirect_pc_o, target); end
            total++; if ({trap_valid_o, rob_ready_o} !== 2'b00) begin bad++; $display("FAIL trap_release got=%b exp=00", {trap_valid_o, rob_ready_o}); end
        end
        @(posedge clk_i); #1;
        rob_valid_i = 1'b0;
        rob_complete_i = 1'b0;
        @(negedge clk_i);
        total++; if ({flush_o, instret_o, trap_valid_o} !== 3'b000) begin bad++; $display("FAIL settle got=%b exp=000", {flush_o, instret_o, trap_valid_o}); end
    endtask

    task automatic test_reset();
        rob_valid_i = 1'b1; rob_complete_i = 1'b1;
        repeat (2) @(negedge clk_i);
        total++; if (rob_ready_o !== 1'b0) begin bad++; $display("FAIL reset_ready got=%0b exp=0", rob_ready_o); end
        total++; if ({gpr_we_o, fpr_we_o, csr_we_o, fflag_we_o, irrevo_go_o, trap_valid_o, flush_o, instret_o} !== 8'h00) begin bad++; $display("FAIL reset_flags got=%b exp=0", {gpr_we_o, fpr_we_o, csr_we_o, fflag_we_o, irrevo_go_o, trap_valid_o, flush_o, instret_o}); end
        total++; if ({trap_epc_o, redirect_pc_o, trap_cause_o, trap_kind_o} !== '0) begin bad++; $display("FAIL reset_fields got=%h/%h exp=0", trap_epc_o, redirect_pc_o); end
        rob_valid_i = 1'b0; rob_complete_i = 1'b0;
        arstn_i = 1'b1;
        @(negedge clk_i);
        total++; if ({trap_valid_o, flush_o} !== 2'b00) begin bad++; $display("FAIL post_reset got=%b exp=00", {trap_valid_o, flush_o}); end
    endtask

    task automatic test_alu();
        head_t h = blank_head();
        h.pc = 64'h8000_0000; h.rden = 1; h.rdidx = 5'd5; h.data = 64'hDEAD_BEEF;
        retire(h, 0, 0, '0);
        h = blank_head();
        h.rden = 1; h.rdidx = 5'd0; h.data = 64'h1234;  // x0 destination
        h.frden = 1; h.frdidx = 5'd7; h.csren = 1; h.csridx = 12'h300;
        h.csrdata = 64'h55; h.fflagen = 1; h.fflag = 5'h1F;
        retire(h, 0, 0, '0);
    endtask

    task automatic test_jump();
        head_t h = blank_head();
        h.pc = 64'h8000_0004; h.jump = 1; h.branch = 64'h8000_0100;
        h.rden = 1; h.rdidx = 5'd1; h.data = 64'h8000_0008;
        retire(h, 0, 0, '0);
    endtask

    task automatic test_trap_priority();
        head_t h = blank_head();
        h.pc = 64'h1000; h.excp.illins = 1; h.excp.instr_pageflt = 1;
        h.rden = 1; h.rdidx = 5'd3;
        retire(h, 0, 4, 64'h8000_0004);
    endtask

    task automatic test_ecall_mret();
        head_t h = blank_head();
        h.ecall = 1; h.priv = 2'd0; h.pc = 64'h2000;
        retire(h, 0, 0, 64'h100);
        h.priv = 2'd3;
        retire(h, 0, 1, 64'h200);
        h = blank_head();
        h.mret = 1; h.pc = 64'h3000;
        retire(h, 0, 2, 64'h4000);
    endtask

    task automatic test_irrevo();
        head_t h = blank_head();
        h.irrevo = 1; h.itag = 8'hA5; h.rden = 1; h.rdidx = 5'd9; h.data = 64'hCAFE;
        retire(h, 10, 0, '0);
    endtask

    task automatic test_random();
        for (int n = 0; n < 60; n++) begin
            head_t h = blank_head();
            int    sp;
            h.pc = {$urandom, $urandom}; h.data = {$urandom, $urandom};
            h.csrdata = {$urandom, $urandom}; h.branch = {$urandom, $urandom};
            if ($urandom_range(0, 3) == 0) h.excp = excp_t'(10'($urandom_range(1, 1023)));
            sp = $urandom_range(0, 9);
            h.ecall = (sp == 0); h.ebreak = (sp == 1); h.mret = (sp == 2); h.sret = (sp == 3);
            h.jump = ($urandom_range(0, 3) == 0); h.irrevo = ($urandom_range(0, 3) == 0);
            h.rden = 1'($urandom); h.rdidx = 5'($urandom);
            h.frden = 1'($urandom); h.frdidx = 5'($urandom);
            h.csren = 1'($urandom); h.csridx = 12'($urandom);
            h.fflagen = 1'($urandom); h.fflag = 5'($urandom);
            h.priv = 2'($urandom);
            retire(h, $urandom_range(0, 3), $urandom_range(0, 3), {$urandom, $urandom});
        end
    endtask

    task automatic test_reset_mid_trap();
        head_t h = blank_head();
        h.pc = 64'h5000; h.excp.illins = 1;
        @(posedge clk_i); #1;
        drive_head(h);
        rob_valid_i = 1'b1; rob_complete_i = 1'b1;
        @(posedge clk_i); #1;
        @(negedge clk_i);
        total++; if (trap_valid_o !== 1'b1) begin bad++; $display("FAIL trap_before_reset got=%0b exp=1", trap_valid_o); end
        @(posedge clk_i); #1;
        arstn_i = 1'b0;
        #1;
        total++; if ({gpr_we_o, fpr_we_o, csr_we_o, fflag_we_o, irrevo_go_o, trap_valid_o, flush_o, instret_o, rob_ready_o} !== 9'h000) begin bad++; $display("FAIL midtrap_reset_flags got=%b exp=0", {gpr_we_o, fpr_we_o, csr_we_o, fflag_we_o, irrevo_go_o, trap_valid_o, flush_o, instret_o, rob_ready_o}); end
        total++; if ({trap_epc_o, trap_cause_o, redirect_pc_o} !== '0) begin bad++; $display("FAIL midtrap_reset_fields got=%h/%0d exp=0", trap_epc_o, trap_cause_o); end
        rob_valid_i = 1'b0; rob_complete_i = 1'b0;
        @(negedge clk_i);
        arstn_i = 1'b1;
        repeat (2) @(negedge clk_i);
        total++; if ({trap_valid_o, flush_o} !== 2'b00) begin bad++; $display("FAIL after_midtrap_reset got=%b exp=00", {trap_valid_o, flush_o}); end
        h = blank_head();
        h.rden = 1; h.rdidx = 5'd12; h.data = 64'h77;
        retire(h, 0, 0, '0);
    endtask

    initial begin
        test_reset();
        test_alu();
        test_jump();
        test_trap_priority();
        test_ecall_mret();
        test_irrevo();
        test_random();
        test_reset_mid_trap();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
